// File: rtl/sensor_disp_conv.sv
// Raw sensor word to signed-tenths 7-segment display patterns.
// Handshake: a sample is taken on any rising edge where in_valid & in_ready; in_ready is high only while idle.
module sensor_disp_conv #(
  parameter int IN_W           = 16,
  parameter int DIGITS         = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk100MHz,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       data_in,
  input  logic                  mode,
  output logic                  out_valid,
  output logic [8*DIGITS-1:0]   seg_out,
  output logic                  sign_neg,
  output logic                  overflow,
  output logic [2:0]            dbg_state
);

  localparam int BW = 4 * DIGITS;
  localparam int PW = IN_W + 11;
  localparam int CW = $clog2(BW) + 1;
  localparam logic [PW-1:0] K_TMP = PW'(1750);
  localparam logic [PW-1:0] K_HUM = PW'(1250);
  localparam logic [8*DIGITS-1:0] SEG_BLANK = {(8*DIGITS){SEG_ACTIVE_LOW}};

  function automatic logic [31:0] pow10_m1(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r - 32'd1;
  endfunction

  localparam logic [31:0] MAXV = pow10_m1(DIGITS);

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MULT  = 3'd1,
    S_SCALE = 3'd2,
    S_CONV  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     data_q, data_d;
  logic                mode_q, mode_d;
  logic [10:0]         phi_q, phi_d;
  logic [12:0]         mag_q, mag_d;
  logic                neg_q, neg_d;
  logic [2*BW-1:0]     sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [8*DIGITS-1:0] seg_q, seg_d;
  logic                sign_q, sign_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;

  logic [PW-1:0]        prod;
  logic [10:0]          phi_c;
  logic signed [12:0]   v_s;
  logic [12:0]          abs_v;
  logic [2*BW-1:0]      dd_adj;
  logic [BW-1:0]        bcd;
  int                   top;
  logic                 ovf_c;
  logic [8*DIGITS-1:0]  seg_c;

  // Datapath pieces evaluated from the registered operands of each stage.
  always_comb begin
    prod  = PW'(data_q) * (mode_q ? K_HUM : K_TMP);
    phi_c = 11'(prod >> IN_W);

    v_s = $signed({2'b00, phi_q}) - (mode_q ? 13'sd60 : 13'sd450);
    if (mode_q) begin
      if (v_s < 13'sd0)         v_s = 13'sd0;
      else if (v_s > 13'sd1000) v_s = 13'sd1000;
    end
    abs_v = v_s[12] ? 13'(-v_s) : 13'(v_s);

    // Shift-add-3: correct every BCD nibble >= 5 before the shift.
    dd_adj = sr_q;
    for (int j = 0; j < DIGITS; j++) begin
      if (dd_adj[BW+4*j +: 4] >= 4'd5) dd_adj[BW+4*j +: 4] = dd_adj[BW+4*j +: 4] + 4'd3;
    end
  end

  // Display encoding from the finished BCD value.
  always_comb begin
    bcd = sr_q[2*BW-1:BW];
    top = 1;
    for (int k = 2; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] != 4'd0) top = k;
    end
    ovf_c = (32'(mag_q) > MAXV) || (neg_q && (top == DIGITS - 1));
    seg_c = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (ovf_c)                      seg_c[8*k +: 8] = 8'h40;
      else if (k <= top)              seg_c[8*k +: 8] = {(k == 1), enc(bcd[4*k +: 4])};
      else if (neg_q && k == top + 1) seg_c[8*k +: 8] = 8'h40;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    phi_d   = phi_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = data_in;
          mode_d  = mode;
          state_d = S_MULT;
        end
      end
      S_MULT: begin
        phi_d   = phi_c;
        state_d = S_SCALE;
      end
      S_SCALE: begin
        neg_d   = v_s[12];
        mag_d   = abs_v;
        sr_d    = {{(2*BW-13){1'b0}}, abs_v};
        cnt_d   = '0;
        state_d = S_CONV;
      end
      S_CONV: begin
        sr_d  = {dd_adj[2*BW-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BW - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        seg_d   = seg_c ^ SEG_BLANK;
        sign_d  = neg_q;
        ovf_d   = ovf_c;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      mode_q  <= 1'b0;
      phi_q   <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      seg_q   <= SEG_BLANK;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      phi_q   <= phi_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = valid_q;
  assign seg_out   = seg_q;
  assign sign_neg  = sign_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule
